fft_8p_frame_loader: RTL and testbench

Front-end stage of the 8-point FFT datapath. It accepts one complex sample per handshake on a streaming input and assembles eight samples into a frame. It presents each completed frame as parallel `x_real`/`x_imag` arrays to the FFT core for one cycle, in natural order; the core does its own bit reversal. It also generates `fft_valid`, which marks the cycle in which the FFT output bins for that frame are valid.

---
 rtl/fft_8p_frame_loader.sv | 101 ++++++++++
 tb/tb_fft_8p_frame_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_8p_frame_loader.sv
// fft_8p_frame_loader: assembles 8 streamed complex samples into a parallel frame for the FFT core
// and delays the frame strobe to qualify the FFT output bins.
module fft_8p_frame_loader #(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 8,
    parameter int FFT_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 arst_n,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic signed [DATA_WIDTH-1:0]         s_real,
    input  logic signed [DATA_WIDTH-1:0]         s_imag,
    input  logic                                 s_last,
    input  logic                                 flush,
    output logic signed [N-1:0][DATA_WIDTH-1:0]  x_real,
    output logic signed [N-1:0][DATA_WIDTH-1:0]  x_imag,
    output logic                                 x_valid,
    output logic                                 fft_valid,
    output logic                                 err_len,
    output logic [15:0]                          frame_cnt
);
    typedef enum logic {ST_RESET, ST_FILL} state_t;
    state_t                        state_q, state_d;
    logic [2:0]                    idx_q, idx_d;
    logic [N-1:0][DATA_WIDTH-1:0]  br_q, br_d, bi_q, bi_d;
    logic [N-1:0][DATA_WIDTH-1:0]  xr_q, xr_d, xi_q, xi_d;
    logic                          xv_q, xv_d, err_q, err_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic [FFT_LATENCY-1:0]        fv_q, fv_d;
    logic                          accept, last_slot;

    assign s_ready   = state_q == ST_FILL;
    assign accept    = s_valid && s_ready;
    assign last_slot = idx_q == 3'(N-1);

    always_comb begin
        state_d = ST_FILL;
        idx_d   = idx_q;
        br_d    = br_q;
        bi_d    = bi_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        xv_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        fv_d    = FFT_LATENCY'({fv_q, xv_q});
        if (flush) begin
            idx_d = '0;
        end else if (accept) begin
            br_d[idx_q] = s_real;
            bi_d[idx_q] = s_imag;
            // the frame copy takes the buffer with the incoming 8th sample already merged in
            if (last_slot && s_last) begin
                xr_d  = br_d;
                xi_d  = bi_d;
                xv_d  = 1'b1;
                cnt_d = cnt_q + 16'd1;
                idx_d = '0;
            end else if (last_slot || s_last) begin
                err_d = 1'b1;
                idx_d = '0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_RESET;
            idx_q   <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            xr_q    <= '0;
            xi_q    <= '0;
            xv_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            fv_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
            xv_q    <= xv_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
        end
    end

    assign x_real    = xr_q;
    assign x_imag    = xi_q;
    assign x_valid   = xv_q;
    assign err_len   = err_q;
    assign frame_cnt = cnt_q;
    assign fft_valid = fv_q[FFT_LATENCY-1];
endmodule

// File: tb/tb_fft_8p_frame_loader.sv
// tb_fft_8p_frame_loader: directed stimulus with a queue of expected frame/error events
// checked by an independent negedge monitor.
module tb_fft_8p_frame_loader;
    localparam int DW = 16;

    logic                   clk = 1'b0, arst_n = 1'b1;
    logic                   s_valid = 1'b0, s_last = 1'b0, flush = 1'b0;
    logic signed [DW-1:0]   s_real = '0, s_imag = '0;
    logic                   s_ready, x_valid, fft_valid, err_len;
    logic signed [7:0][DW-1:0] x_real, x_imag;
    logic [15:0]            frame_cnt;

    typedef struct {
        bit              is_err;
        logic [7:0][15:0] xr;
        logic [7:0][15:0] xi;
        logic [15:0]     cnt;
    } ev_t;

    ev_t  q[$];
    int   cmp = 0, mism = 0, fv_count = 0, cyc = 0;
    int   xv_times[$];
    logic [1:0] xv_h = '0;

    fft_8p_frame_loader #(.DATA_WIDTH(DW), .N(8), .FFT_LATENCY(2)) dut (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .s_last(s_last), .flush(flush),
        .x_real(x_real), .x_imag(x_imag), .x_valid(x_valid), .fft_valid(fft_valid),
        .err_len(err_len), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][15:0] mk(input int base, input int step);
        logic [7:0][15:0] v;
        for (int k = 0; k < 8; k++) v[k] = 16'(base + step * k);
        return v;
    endfunction

    task automatic expect_frame(input int rb, input int rs, input int ib, input int is, input int cnt);
        ev_t e;
        e.is_err = 1'b0;
        e.xr = mk(rb, rs);
        e.xi = mk(ib, is);
        e.cnt = 16'(cnt);
        q.push_back(e);
    endtask

    task automatic expect_err();
        ev_t e;
        e.is_err = 1'b1;
        e.xr = '0;
        e.xi = '0;
        e.cnt = '0;
        q.push_back(e);
    endtask

    task automatic send(input int r, input int im, input bit last, input bit fl);
        s_valid = 1'b1;
        s_real  = 16'(r);
        s_imag  = 16'(im);
        s_last  = last;
        flush   = fl;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic send_frame(input int rb, input int ib, input int is);
        for (int k = 0; k < 8; k++) send(rb + k, ib + is * k, k == 7, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (!arst_n) begin
            xv_h = '0;
        end else begin
            if (x_valid && err_len) chk("xv_err_overlap", 1, 0);
            if (x_valid || err_len) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {x_valid, err_len}, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", err_len, e.is_err);
                    if (!e.is_err) begin
                        chk("x_real", x_real, e.xr);
                        chk("x_imag", x_imag, e.xi);
                        chk("frame_cnt", frame_cnt, e.cnt);
                        xv_times.push_back(cyc);
                    end
                end
            end
            if (fft_valid || xv_h[1]) chk("fft_valid", fft_valid, xv_h[1]);
            if (fft_valid) fv_count++;
            xv_h = {xv_h[0], x_valid};
        end
    end

    initial begin
        int s, n;
        #1 arst_n = 1'b0;
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_x_real", x_real, 0);
        chk("rst_x_imag", x_imag, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_fft_valid", fft_valid, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        #9 arst_n = 1'b1;
        #1 chk("ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1 chk("ready_after_edge", s_ready, 1);

        // single frame real=1..8, imag=0
        expect_frame(1, 1, 0, 0, 1);
        send_frame(1, 0, 0);
        idle(4);
        s = 0;
        for (int k = 0; k < 8; k++) s += int'(x_real[k]);
        chk("bin0_real", s, 36);
        chk("cnt_after_1", frame_cnt, 1);
        chk("fv_after_1", fv_count, 1);

        // three back-to-back frames
        for (int f = 0; f < 3; f++) expect_frame(16 * f + 16, 1, 100 * f + 50, 3, f + 2);
        for (int f = 0; f < 3; f++) send_frame(16 * f + 16, 100 * f + 50, 3);
        idle(4);
        n = xv_times.size();
        chk("b2b_count", n, 4);
        if (n >= 3) begin
            chk("b2b_gap1", xv_times[n-2] - xv_times[n-3], 8);
            chk("b2b_gap2", xv_times[n-1] - xv_times[n-2], 8);
        end
        chk("cnt_after_b2b", frame_cnt, 4);
        chk("fv_after_b2b", fv_count, 4);

        // s_last on the 5th sample, then a clean frame
        expect_err();
        for (int k = 0; k < 5; k++) send(900 + k, 0, k == 4, 1'b0);
        expect_frame(200, 1, 7, 2, 5);
        send_frame(200, 7, 2);
        idle(3);

        // 8 samples without s_last: error, outputs held, then idx restarts
        expect_err();
        for (int k = 0; k < 8; k++) send(300 + k, 1, 1'b0, 1'b0);
        idle(2);
        chk("hold_x_real", x_real, mk(200, 1));
        chk("hold_x_imag", x_imag, mk(7, 2));
        expect_frame(400, 1, 20, 1, 6);
        send_frame(400, 20, 1);
        idle(3);

        // flush with a valid sample at index 3, then a fresh frame
        for (int k = 0; k < 3; k++) send(700 + k, 700, 1'b0, 1'b0);
        send(703, 703, 1'b1, 1'b1);
        expect_frame(500, 1, 0, 5, 7);
        send_frame(500, 0, 5);
        idle(3);

        // asynchronous reset after 4 samples
        for (int k = 0; k < 4; k++) send(800 + k, 0, 1'b0, 1'b0);
        #3 arst_n = 1'b0;
        #1;
        chk("mrst_x_real", x_real, 0);
        chk("mrst_x_imag", x_imag, 0);
        chk("mrst_x_valid", x_valid, 0);
        chk("mrst_fft_valid", fft_valid, 0);
        chk("mrst_err_len", err_len, 0);
        chk("mrst_frame_cnt", frame_cnt, 0);
        chk("mrst_s_ready", s_ready, 0);
        #3 arst_n = 1'b1;
        #1 chk("mrst_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1 chk("mrst_ready_after_edge", s_ready, 1);
        expect_frame(600, 1, 30, 1, 1);
        send_frame(600, 30, 1);
        idle(6);
        chk("final_frame_cnt", frame_cnt, 1);
        chk("pending_events", q.size(), 0);
        chk("fv_total", fv_count, 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
